// File: rtl/branch_target_buffer_pkg.sv
// Shared fetch-stage definitions: PC geometry, BTB update operations and
// index/tag extraction helpers (also used by the direction predictor's table).
package branch_target_buffer_pkg;

   localparam int ADDR_W_DEFAULT = 32;
   localparam int PC_INC         = 4;

   typedef enum logic [1:0] {
      UPD_NONE  = 2'd0,
      UPD_WRITE = 2'd1,
      UPD_INVAL = 2'd2
   } upd_op_t;

   function automatic int tag_width(input int addr_w, input int index_w);
      return addr_w - index_w - 2;
   endfunction

   // Word-aligned PCs: bits [1:0] never participate in indexing.
   function automatic logic [63:0] pc_index(input logic [63:0] pc, input int index_w);
      return (pc >> 2) & ((64'd1 << index_w) - 64'd1);
   endfunction

   function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int index_w);
      return pc >> (index_w + 2);
   endfunction

endpackage

// File: rtl/branch_target_buffer_storage.sv
// BTB entry storage: per-entry valid bits with asynchronous clear plus an
// unreset tag/target array; one combinational read port, one write port.
module btb_storage
   import branch_target_buffer_pkg::*;
#(
   parameter int ENTRIES = 64,
   parameter int INDEX_W = 6,
   parameter int TAG_W   = 24,
   parameter int TGT_W   = 30
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [INDEX_W-1:0] rd_idx,
   output logic               rd_valid,
   output logic [TAG_W-1:0]   rd_tag,
   output logic [TGT_W-1:0]   rd_target,
   input  logic               wr_en,
   input  logic [INDEX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [TGT_W-1:0]   wr_target,
   input  logic               inv_en,
   input  logic [INDEX_W-1:0] inv_idx,
   input  logic [TAG_W-1:0]   inv_tag,
   input  logic               flush
);

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [TGT_W-1:0] target;
   } entry_t;

   entry_t             mem_reg [ENTRIES];
   logic [ENTRIES-1:0] valid_reg;
   logic [ENTRIES-1:0] valid_next;
   logic               inv_match;

   // Invalidation only drops the entry if it really belongs to the reported PC.
   assign inv_match = valid_reg[inv_idx] && (mem_reg[inv_idx].tag == inv_tag);

   genvar gi;
   generate
      for (gi = 0; gi < ENTRIES; gi++) begin : g_valid
         assign valid_next[gi] = flush                                          ? 1'b0 :
                                 (wr_en && wr_idx == INDEX_W'(gi))              ? 1'b1 :
                                 (inv_en && inv_match && inv_idx == INDEX_W'(gi)) ? 1'b0 :
                                 valid_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) valid_reg <= '0;
      else       valid_reg <= valid_next;
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_reg[wr_idx] <= '{tag: wr_tag, target: wr_target};
   end

   assign rd_valid  = valid_reg[rd_idx];
   assign rd_tag    = mem_reg[rd_idx].tag;
   assign rd_target = mem_reg[rd_idx].target;

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB and next-PC selector: zero-latency lookup of fetch_pc,
// redirect on predicted-taken hits, updates from resolved branches.
module branch_target_buffer
   import branch_target_buffer_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEFAULT,
   parameter int ENTRIES = 64
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              fetch_valid,
   input  logic [ADDR_W-1:0] fetch_pc,
   input  logic              predict_taken,
   output logic [ADDR_W-1:0] next_pc,
   output logic              btb_hit,
   output logic              pred_redirect,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_is_branch,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              flush
);

   localparam int INDEX_W = $clog2(ENTRIES);
   localparam int TAG_W   = tag_width(ADDR_W, INDEX_W);
   localparam int TGT_W   = ADDR_W - 2;

   logic [INDEX_W-1:0] fetch_idx;
   logic [TAG_W-1:0]   fetch_tag;
   logic [INDEX_W-1:0] upd_idx;
   logic [TAG_W-1:0]   upd_tag;
   logic               rd_valid;
   logic [TAG_W-1:0]   rd_tag;
   logic [TGT_W-1:0]   rd_target;
   upd_op_t            upd_op;

   assign fetch_idx = INDEX_W'(pc_index(64'(fetch_pc), INDEX_W));
   assign fetch_tag = TAG_W'(pc_tag(64'(fetch_pc), INDEX_W));
   assign upd_idx   = INDEX_W'(pc_index(64'(upd_pc), INDEX_W));
   assign upd_tag   = TAG_W'(pc_tag(64'(upd_pc), INDEX_W));

   // Flush wins over a same-cycle update; not-taken branches leave the entry alone.
   always_comb begin
      upd_op = UPD_NONE;
      if (upd_valid && !flush) begin
         if (upd_is_branch && upd_taken) upd_op = UPD_WRITE;
         else if (!upd_is_branch)        upd_op = UPD_INVAL;
      end
   end

   btb_storage #(
      .ENTRIES (ENTRIES),
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W),
      .TGT_W   (TGT_W)
   ) u_storage (
      .clk       (clk),
      .rstn      (rstn),
      .rd_idx    (fetch_idx),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_target (rd_target),
      .wr_en     (upd_op == UPD_WRITE),
      .wr_idx    (upd_idx),
      .wr_tag    (upd_tag),
      .wr_target (TGT_W'(upd_target >> 2)),
      .inv_en    (upd_op == UPD_INVAL),
      .inv_idx   (upd_idx),
      .inv_tag   (upd_tag),
      .flush     (flush)
   );

   assign btb_hit       = rd_valid && (rd_tag == fetch_tag);
   assign pred_redirect = fetch_valid && btb_hit && predict_taken;

   always_comb begin
      next_pc = fetch_pc;
      if (pred_redirect)    next_pc = {rd_target, 2'b00};
      else if (fetch_valid) next_pc = fetch_pc + ADDR_W'(PC_INC);
   end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer and next-PC selector for the fetch stage. It sits directly downstream of the 2-bit saturating-counter direction predictor: it takes the predictor's taken/not-taken bit for the current fetch PC, looks up a stored target, and produces the next fetch PC. Resolved branches from execute update the buffer.

## Interface
- ADDR_W, 32, PC width in bits; PCs are word-aligned, bits [1:0] ignored
- ENTRIES, 64, number of BTB entries; power of two, ≥ 2
- INDEX_W, log2(ENTRIES), derived; not overridden
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- fetch_valid  input  1  fetch_pc is a real fetch this cycle
- fetch_pc  input  ADDR_W  current fetch address
- predict_taken  input  1  direction from the saturating-counter predictor for fetch_pc
- next_pc  output  ADDR_W  address to fetch next cycle
- btb_hit  output  1  valid entry with matching tag for fetch_pc
- pred_redirect  output  1  fetch_valid & btb_hit & predict_taken
- upd_valid  input  1  resolved instruction report from execute
- upd_pc  input  ADDR_W  PC of resolved instruction
- upd_is_branch  input  1  resolved instruction is a branch/jump
- upd_taken  input  1  branch actually taken
- upd_target  input  ADDR_W  actual taken target
- flush  input  1  invalidate all entries (context switch / self-modifying code)

## Operation
- Index = pc[INDEX_W+1:2]; tag = pc[ADDR_W-1:INDEX_W+2]. Entry = {valid, tag, target[ADDR_W-1:2]}.
- Lookup is combinational from registered storage: btb_hit = valid[idx] & (tag[idx] == fetch tag).
- next_pc = pred_redirect ? {target[idx], 2'b00} : fetch_pc + 4 (mod 2^ADDR_W, wraps 0xFFFF_FFFC → 0x0000_0000). With fetch_valid=0: next_pc = fetch_pc, btb_hit still computed, pred_redirect=0.
- Update rules, applied on clock edge when upd_valid=1:
  - is_branch & taken: write entry {1, tag, target} (allocate or overwrite, evicting any alias).
  - is_branch & not taken: no change (entry kept; direction handled by predictor).
  - !is_branch & tag hit: clear valid (stale alias of a non-branch).
  - !is_branch & miss: no change.
- flush=1: all valid bits cleared at next edge; flush takes priority over a same-cycle update (update dropped).
- Tag/target storage need not be reset; only valid bits are.

## Timing
- Reset: all valid=0; thus btb_hit=0, pred_redirect=0, next_pc = fetch_pc+4 (fetch_valid=1) or fetch_pc.
- Lookup latency 0 cycles (same-cycle next_pc). Update visible to lookups from the cycle after the write edge.
- Same-cycle update and lookup to the same index: lookup returns pre-update contents; no bypass.
- Reset asserted mid-operation: valid bits clear immediately (asynchronous); outputs follow within the same cycle.
- No backpressure; every upd_valid cycle is consumed.

## Structure
- Shared package: ADDR_W default, PC increment constant (4), btb entry field widths/typedef, index/tag extraction functions (reused by the predictor's table indexing).
- One natural sub-module: btb_storage (valid-bit register array with async reset + tag/target array, 1 read port, 1 write port, bulk-invalidate).
- Top: index/tag split, hit compare, update decision, next-PC mux.

## Test plan
- After reset, fetch_pc=0x0000_1000, predict_taken=1 → btb_hit=0, next_pc=0x0000_1004.
- Update pc=0x1000, branch, taken, target=0x2000; next cycle fetch 0x1000, predict_taken=1 → btb_hit=1, next_pc=0x2000; with predict_taken=0 → next_pc=0x1004.
- Alias: after above, update pc=0x1100 (same index, different tag) taken target=0x3000 → fetch 0x1000 misses (next_pc 0x1004), fetch 0x1100 hits → 0x3000; then update pc=0x1100 !is_branch → fetch 0x1100 misses.
- Same-cycle update to 0x1000 (target 0x4000) and fetch 0x1000 → this cycle next_pc=0x2000, following cycle 0x4000.
- flush with simultaneous taken update pc=0x1200 → next cycle both 0x1000 and 0x1200 miss.
- fetch_pc=0xFFFF_FFFC miss → next_pc=0x0000_0000; rstn pulsed low mid-run → all previously valid entries miss.
